// File: rtl/sr_mem_axi_bridge.sv
// sr_cpu load/store port to single-beat AXI4 master bridge.
// Optional sticky error status: define SR_MEM_AXI_ERR_STATUS_EN.
module sr_mem_axi_bridge #(
    parameter int                 ADDR_W    = 32,
    parameter int                 ID_W      = 4,
    parameter logic [ID_W-1:0]    AXI_ID    = '0,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SR_MEM_AXI_ERR_STATUS_EN
    output logic              err_o,
    output logic [15:0]       err_addr_o,
    input  logic              err_clr_i,
`endif
    input  logic              mem_wr_i,
    input  logic [15:0]       mem_addr_i,
    input  logic              mem_req_valid_i,
    output logic              mem_req_ready_o,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_resp_valid_o,
    input  logic              mem_resp_ready_i,
    output logic [31:0]       mem_rdata_o,
    output logic [ID_W-1:0]   m_awid,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [ID_W-1:0]   m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD,
        RSP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [15:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              aw_done;
    logic              w_done;
    logic [ADDR_W-1:0] axi_addr;

    assign axi_addr = BASE_ADDR + ADDR_W'({addr_q[15:2], 2'b00});

    assign m_awid    = AXI_ID;
    assign m_awaddr  = axi_addr;
    assign m_awlen   = 8'd0;
    assign m_awsize  = 3'b010;
    assign m_awburst = 2'b01;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = 4'hF;
    assign m_wlast   = 1'b1;
    assign m_arid    = AXI_ID;
    assign m_araddr  = axi_addr;
    assign m_arlen   = 8'd0;
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;

    assign mem_rdata_o = rdata_q;

    always_comb begin
        state_nx         = state;
        mem_req_ready_o  = 1'b0;
        mem_resp_valid_o = 1'b0;
        m_awvalid        = 1'b0;
        m_wvalid         = 1'b0;
        m_bready         = 1'b0;
        m_arvalid        = 1'b0;
        m_rready         = 1'b0;
        case (state)
            IDLE: begin
                mem_req_ready_o = 1'b1;
                if (mem_req_valid_i) begin
                    state_nx = mem_wr_i ? WR : RA;
                end
            end
            WR: begin
                // AW and W retire independently, in either order
                m_awvalid = !aw_done;
                m_wvalid  = !w_done;
                if ((aw_done || m_awready) && (w_done || m_wready)) begin
                    state_nx = WB;
                end
            end
            WB: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    state_nx = RSP;
                end
            end
            RA: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_nx = RD;
                end
            end
            RD: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    state_nx = RSP;
                end
            end
            RSP: begin
                mem_resp_valid_o = 1'b1;
                if (mem_resp_ready_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && mem_req_valid_i) begin
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
            end
            if (state == WR && state_nx != WR) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == WR) begin
                aw_done <= aw_done || m_awready;
                w_done  <= w_done || m_wready;
            end
            if (state == RD && m_rvalid) begin
                rdata_q <= m_rdata;
            end
        end
    end

`ifdef SR_MEM_AXI_ERR_STATUS_EN
    logic err_evt;

    assign err_evt = (state == WB && m_bvalid && m_bresp != 2'b00) ||
                     (state == RD && m_rvalid && m_rresp != 2'b00);

    // a new error outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (err_evt) begin
            err_o <= 1'b1;
            if (!err_o) begin
                err_addr_o <= addr_q;
            end
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{m_bid, m_rid, m_rlast};
`else
    logic unused_ok;
    assign unused_ok = ^{m_bid, m_rid, m_rlast, m_bresp, m_rresp, addr_q[1:0]};
`endif

endmodule

// File: tb/tb_sr_mem_axi_bridge.sv
// Bench for sr_mem_axi_bridge: vector table, AXI slave model, response scoreboard.
// Error-status checks compile when SR_MEM_AXI_ERR_STATUS_EN is defined.
module tb_sr_mem_axi_bridge;

    localparam int          ADDR_W = 32;
    localparam int          ID_W   = 4;
    localparam logic [3:0]  AXI_ID = 4'h3;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic clk;
    logic rst;
    logic mem_wr_i;
    logic [15:0] mem_addr_i;
    logic mem_req_valid_i;
    logic mem_req_ready_o;
    logic [31:0] mem_wdata_i;
    logic mem_resp_valid_o;
    logic mem_resp_ready_i;
    logic [31:0] mem_rdata_o;
    logic [ID_W-1:0] m_awid, m_arid, m_bid, m_rid;
    logic [ADDR_W-1:0] m_awaddr, m_araddr;
    logic [7:0] m_awlen, m_arlen;
    logic [2:0] m_awsize, m_arsize;
    logic [1:0] m_awburst, m_arburst;
    logic m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0] m_wstrb;
    logic m_wlast;
    logic [1:0] m_bresp, m_rresp;
    logic m_bvalid, m_bready, m_arvalid, m_arready;
    logic m_rlast, m_rvalid, m_rready;
`ifdef SR_MEM_AXI_ERR_STATUS_EN
    logic err_o;
    logic [15:0] err_addr_o;
    logic err_clr_i;
`endif

    sr_mem_axi_bridge #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(AXI_ID), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef SR_MEM_AXI_ERR_STATUS_EN
        .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i),
`endif
        .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
        .mem_req_valid_i(mem_req_valid_i), .mem_req_ready_o(mem_req_ready_o),
        .mem_wdata_i(mem_wdata_i), .mem_resp_valid_o(mem_resp_valid_o),
        .mem_resp_ready_i(mem_resp_ready_i), .mem_rdata_o(mem_rdata_o),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [15:0] a);
        logic [31:0] w;
        w = {16'h0000, a[15:2], 2'b00};
        return BASE + w;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // AXI slave model: per-channel wait counts, responses after both AW and W
    int aw_w, w_w, b_w, ar_w, r_w;
    logic [1:0] cfg_resp;
    logic [31:0] cfg_rdata;
    int aw_c, w_c, b_c, ar_c, r_c;
    logic aw_got, w_got, b_pend, r_pend;
    int n_aw, n_w, n_b, n_ar, n_r;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;

    assign m_awready = m_awvalid && (aw_c >= aw_w);
    assign m_wready  = m_wvalid && (w_c >= w_w);
    assign m_arready = m_arvalid && (ar_c >= ar_w);
    assign m_bvalid  = b_pend && (b_c >= b_w);
    assign m_rvalid  = r_pend && (r_c >= r_w);
    assign m_bresp   = cfg_resp;
    assign m_rresp   = cfg_resp;
    assign m_bid     = AXI_ID;
    assign m_rid     = AXI_ID;
    assign m_rlast   = 1'b1;
    assign m_rdata   = m_rvalid ? cfg_rdata : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst) begin
            aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_c <= (m_awvalid && !m_awready) ? aw_c + 1 : 0;
            w_c  <= (m_wvalid && !m_wready) ? w_c + 1 : 0;
            ar_c <= (m_arvalid && !m_arready) ? ar_c + 1 : 0;
            b_c  <= (b_pend && !m_bvalid) ? b_c + 1 : 0;
            r_c  <= (r_pend && !m_rvalid) ? r_c + 1 : 0;
            if (m_awvalid && m_awready) begin
                n_aw <= n_aw + 1;
                cap_awaddr <= m_awaddr;
            end
            if (m_wvalid && m_wready) begin
                n_w <= n_w + 1;
                cap_wdata <= m_wdata;
            end
            if ((aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready))) begin
                b_pend <= 1'b1;
                aw_got <= 1'b0;
                w_got <= 1'b0;
            end else begin
                if (m_awvalid && m_awready) aw_got <= 1'b1;
                if (m_wvalid && m_wready) w_got <= 1'b1;
            end
            if (m_bvalid && m_bready) begin
                b_pend <= 1'b0;
                n_b <= n_b + 1;
            end
            if (m_arvalid && m_arready) begin
                r_pend <= 1'b1;
                n_ar <= n_ar + 1;
                cap_araddr <= m_araddr;
            end
            if (m_rvalid && m_rready) begin
                r_pend <= 1'b0;
                n_r <= n_r + 1;
            end
        end
    end

    // protocol watch: valids held until handshake, constant fields
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    always @(negedge clk) begin
        if (!rst) begin
            if (p_awv && !p_awr) chk("aw_hold", m_awvalid, 1);
            if (p_wv && !p_wr) chk("w_hold", m_wvalid, 1);
            if (p_arv && !p_arr) chk("ar_hold", m_arvalid, 1);
            if (m_awvalid && m_awready)
                chk("aw_fields", {m_awid, m_awlen, m_awsize, m_awburst}, {AXI_ID, 8'd0, 3'b010, 2'b01});
            if (m_wvalid && m_wready)
                chk("w_fields", {m_wstrb, m_wlast}, {4'hF, 1'b1});
            if (m_arvalid && m_arready)
                chk("ar_fields", {m_arid, m_arlen, m_arsize, m_arburst}, {AXI_ID, 8'd0, 3'b010, 2'b01});
        end
        p_awv = m_awvalid; p_awr = m_awready;
        p_wv = m_wvalid; p_wr = m_wready;
        p_arv = m_arvalid; p_arr = m_arready;
    end

    // response scoreboard
    logic [31:0] sb[$];
    logic [31:0] model_rdata;
    int n_resp = 0;
    int first_rv_cyc = 0;
    logic prev_rv = 1'b0;
    logic prev_rr = 1'b0;
    logic [31:0] prev_rdata;
    always @(negedge clk) begin
        if (!rst && mem_resp_valid_o) begin
            if (!prev_rv) first_rv_cyc = cyc;
            if (prev_rv && !prev_rr) chk("rdata_stable", mem_rdata_o, prev_rdata);
            if (mem_resp_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata %h expected none", mem_rdata_o);
                end else begin
                    chk("resp_rdata", mem_rdata_o, sb.pop_front());
                end
                n_resp++;
            end
        end
        prev_rv = mem_resp_valid_o && !rst;
        prev_rr = mem_resp_ready_i;
        prev_rdata = mem_rdata_o;
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw_w;
        int          w_w;
        int          b_w;
        int          ar_w;
        int          r_w;
        logic [1:0]  resp;
        int          hold;
        int          lat;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int na0, nw0, nb0, nar0, nr0, nresp0, acc, to;
        logic [31:0] expd;
        aw_w = v.aw_w; w_w = v.w_w; b_w = v.b_w;
        ar_w = v.ar_w; r_w = v.r_w;
        cfg_resp = v.resp; cfg_rdata = v.rdata;
        na0 = n_aw; nw0 = n_w; nb0 = n_b; nar0 = n_ar; nr0 = n_r; nresp0 = n_resp;
        @(posedge clk); #1;
        if (v.hold > 0) mem_resp_ready_i = 1'b0;
        mem_req_valid_i = 1'b1;
        mem_wr_i = v.wr;
        mem_addr_i = v.addr;
        mem_wdata_i = v.wdata;
        @(negedge clk);
        to = 0;
        while (!mem_req_ready_o && to < 50) begin
            @(negedge clk);
            to++;
        end
        chk("req_accept", (to < 50) ? 1 : 0, 1);
        acc = cyc;
        expd = v.wr ? model_rdata : v.rdata;
        if (!v.wr) model_rdata = v.rdata;
        sb.push_back(expd);
        @(posedge clk); #1;
        mem_req_valid_i = 1'b0;
        mem_addr_i = 16'hFFFF;
        mem_wdata_i = 32'h0;
        if (v.hold > 0) begin
            to = 0;
            while (!mem_resp_valid_o && to < 100) begin
                @(negedge clk);
                to++;
            end
            @(posedge clk); #1;
            mem_req_valid_i = 1'b1;
            mem_wr_i = 1'b1;
            mem_addr_i = 16'h7770;
            for (int i = 0; i < v.hold; i++) begin
                @(negedge clk);
                chk("hold_valid", mem_resp_valid_o, 1);
                chk("hold_req_ready", mem_req_ready_o, 0);
                chk("hold_rdata", mem_rdata_o, expd);
                @(posedge clk); #1;
            end
            mem_resp_ready_i = 1'b1;
            mem_req_valid_i = 1'b0;
        end
        to = 0;
        while (n_resp == nresp0 && to < 200) begin
            @(negedge clk);
            to++;
        end
        chk("resp_wait", (to < 200) ? 1 : 0, 1);
        if (v.lat >= 0) chk("latency", first_rv_cyc - acc, v.lat);
        @(negedge clk);
        chk("resp_pulse", mem_resp_valid_o, 0);
        chk("n_aw", n_aw - na0, v.wr ? 1 : 0);
        chk("n_w", n_w - nw0, v.wr ? 1 : 0);
        chk("n_b", n_b - nb0, v.wr ? 1 : 0);
        chk("n_ar", n_ar - nar0, v.wr ? 0 : 1);
        chk("n_r", n_r - nr0, v.wr ? 0 : 1);
        if (v.wr) begin
            chk("awaddr", cap_awaddr, exp_addr(v.addr));
            chk("wdata", cap_wdata, v.wdata);
        end else begin
            chk("araddr", cap_araddr, exp_addr(v.addr));
        end
    endtask

    vec_t vecs[9];
    vec_t t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wr    addr      wdata         rdata         aw w  b  ar r  resp   hold lat
        vecs[0] = '{1'b1, 16'h0104, 32'hCAFE_F00D, 32'h0,        0, 0, 0, 0, 0, 2'b00, 0, 3};
        vecs[1] = '{1'b0, 16'h0040, 32'h0,        32'h1234_5678, 0, 0, 0, 2, 5, 2'b00, 0, -1};
        vecs[2] = '{1'b1, 16'h0ABE, 32'h1111_2222, 32'h0,        3, 0, 1, 0, 0, 2'b00, 0, -1};
        vecs[3] = '{1'b1, 16'h1000, 32'h3333_4444, 32'h0,        0, 3, 0, 0, 0, 2'b00, 0, -1};
        vecs[4] = '{1'b0, 16'hFFFC, 32'h0,        32'hA5A5_5A5A, 0, 0, 0, 0, 0, 2'b00, 0, 3};
        vecs[5] = '{1'b0, 16'h0203, 32'h0,        32'h0BAD_0BAD, 0, 0, 0, 1, 1, 2'b10, 0, -1};
        vecs[6] = '{1'b1, 16'h0008, 32'h7777_8888, 32'h0,        0, 0, 2, 0, 0, 2'b11, 0, -1};
        vecs[7] = '{1'b0, 16'h0010, 32'h0,        32'h5555_AAAA, 0, 0, 0, 0, 0, 2'b00, 4, 3};
        vecs[8] = '{1'b1, 16'h0020, 32'h9999_0000, 32'h0,        2, 2, 0, 0, 0, 2'b00, 0, -1};

        rst = 1'b1;
        mem_wr_i = 1'b0;
        mem_addr_i = '0;
        mem_wdata_i = '0;
        mem_req_valid_i = 1'b0;
        mem_resp_ready_i = 1'b1;
        aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
        cfg_resp = 2'b00; cfg_rdata = '0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        cap_awaddr = '0; cap_wdata = '0; cap_araddr = '0;
        model_rdata = '0;
`ifdef SR_MEM_AXI_ERR_STATUS_EN
        err_clr_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", mem_req_ready_o, 1);
        chk("rst_resp_valid", mem_resp_valid_o, 0);
        chk("rst_rdata", mem_rdata_o, 0);
        chk("rst_axi", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
`ifdef SR_MEM_AXI_ERR_STATUS_EN
        chk("rst_err", {err_o, err_addr_o}, 0);
        t = '{1'b0, 16'h0200, 32'h0, 32'h2222_0000, 0, 0, 0, 0, 1, 2'b10, 0, -1};
        run_vec(t);
        chk("err_set", err_o, 1);
        chk("err_addr", err_addr_o, 16'h0200);
        t = '{1'b1, 16'h0300, 32'h1, 32'h0, 0, 0, 0, 0, 0, 2'b10, 0, -1};
        run_vec(t);
        chk("err_keep_addr", err_addr_o, 16'h0200);
        @(posedge clk); #1 err_clr_i = 1'b1;
        @(posedge clk); #1 err_clr_i = 1'b0;
        @(negedge clk);
        chk("err_clr", err_o, 0);
`endif

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

`ifdef SR_MEM_AXI_ERR_STATUS_EN
        chk("err_after_table", err_o, 1);
        chk("err_addr_table", err_addr_o, 16'h0203);
`endif

        // reset while waiting for R aborts the load
        ar_w = 0; r_w = 20; cfg_resp = 2'b00; cfg_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        mem_req_valid_i = 1'b1;
        mem_wr_i = 1'b0;
        mem_addr_i = 16'h0044;
        @(posedge clk); #1;
        mem_req_valid_i = 1'b0;
        begin
            int to;
            to = 0;
            @(negedge clk);
            while (!m_rready && to < 50) begin
                @(negedge clk);
                to++;
            end
        end
        chk("rd_reached", m_rready, 1);
        @(posedge clk); #1 rst = 1'b1;
        sb.delete();
        model_rdata = '0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_axi", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        chk("abort_req_ready", mem_req_ready_o, 1);
        chk("abort_resp_valid", mem_resp_valid_o, 0);
        chk("abort_rdata", mem_rdata_o, 0);
        t = '{1'b0, 16'h0048, 32'h0, 32'h0F0F_1234, 0, 0, 0, 1, 1, 2'b00, 0, -1};
        run_vec(t);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
